// File: rtl/spike_log_pkg.sv
// Shared types and constants for the spike event logger.
package spike_log_pkg;

  localparam int TS_W_DEFAULT = 12;

  localparam logic [1:0] EV_N1   = 2'b01;
  localparam logic [1:0] EV_N2   = 2'b10;
  localparam logic [1:0] EV_BOTH = 2'b11;

  typedef struct packed {
    logic [1:0]              mask;
    logic [TS_W_DEFAULT-1:0] ts;
  } spike_ev_t;

endpackage

// File: rtl/spike_fifo.sv
// Generic synchronous FIFO; pointers carry one extra wrap bit to tell full from empty.
module spike_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Unwritten memory is never exposed; an empty FIFO presents zero.
  assign rd_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/spike_event_logger.sv
// Timestamps rising edges of two spike lines and queues them as {mask, ts} events.
// Optional SPIKE_LOG_DROP_CNT_EN adds a saturating dropped-event counter.
module spike_event_logger
  import spike_log_pkg::*;
#(
  parameter int TS_W  = TS_W_DEFAULT,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic [1:0]               spike_in,
  input  logic                     ev_ready,
  input  logic                     clr_ovf,
  output logic                     ev_valid,
  output logic [TS_W+1:0]          ev_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  logic [TS_W-1:0] ts_reg;
  logic [1:0]      prev_reg;
  logic [1:0]      edge_vec;
  logic            ev_gen;
  logic            pop_fire;
  logic            fifo_full;
  logic            fifo_empty;
  logic            drop;
  logic            overflow_reg;

  assign edge_vec = spike_in & ~prev_reg;
  assign ev_gen   = ena & (|edge_vec) & ~rst;
  assign pop_fire = ev_valid & ev_ready;
  assign drop     = ev_gen & fifo_full & ~pop_fire;
  assign ev_valid = ~fifo_empty;
  assign overflow = overflow_reg;

  // prev tracks spike_in even while disabled so re-enabling cannot fake an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_reg       <= '0;
      prev_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      prev_reg <= spike_in;
      if (ena) ts_reg <= ts_reg + 1'b1;
      if (drop)         overflow_reg <= 1'b1;
      else if (clr_ovf) overflow_reg <= 1'b0;
    end
  end

  spike_fifo #(
    .WIDTH (TS_W + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (ev_gen),
    .wr_data ({edge_vec, ts_reg}),
    .pop     (ev_ready),
    .rd_data (ev_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

`ifdef SPIKE_LOG_DROP_CNT_EN
  logic [7:0] drop_cnt_reg;

  // A drop coinciding with a clear restarts the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_reg <= '0;
    end else if (drop) begin
      if (clr_ovf)                   drop_cnt_reg <= 8'd1;
      else if (drop_cnt_reg != 8'hFF) drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end else if (clr_ovf) begin
      drop_cnt_reg <= '0;
    end
  end

  assign drop_cnt = drop_cnt_reg;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_spike_event_logger.sv
// Directed plus random stimulus against a queue-based model of the spike event logger.
module tb_spike_event_logger;
  import spike_log_pkg::*;

  localparam int TS_W  = 5;
  localparam int DEPTH = 8;
  localparam int EW    = TS_W + 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   ena = 1'b0;
  logic [1:0]             spike_in = 2'b00;
  logic                   ev_ready = 1'b0;
  logic                   clr_ovf = 1'b0;
  logic                   ev_valid;
  logic [EW-1:0]          ev_data;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   overflow;
  logic [7:0]             drop_cnt;

  spike_event_logger #(.TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .spike_in   (spike_in),
    .ev_ready   (ev_ready),
    .clr_ovf    (clr_ovf),
    .ev_valid   (ev_valid),
    .ev_data    (ev_data),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: event queue, enabled-cycle timestamp, last sampled spikes.
  logic [EW-1:0] q[$];
  int            m_ts = 0;
  logic [1:0]    m_prev = 2'b00;
  logic          m_ovf = 1'b0;
  int            m_drops = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_drops(input int n);
`ifdef SPIKE_LOG_DROP_CNT_EN
    return 32'(n);
`else
    return 32'(n * 0);
`endif
  endfunction

  task automatic cycle(input logic [1:0] sp, input logic en, input logic rdy,
                       input logic clr, input logic rs);
    logic [1:0] e;
    logic       ev;
    logic       dropped;
    spike_in = sp; ena = en; ev_ready = rdy; clr_ovf = clr; rst = rs;
    @(posedge clk);
    #1;
    if (rs) begin
      q.delete();
      m_ts = 0; m_prev = 2'b00; m_ovf = 1'b0; m_drops = 0;
    end else begin
      e = sp & ~m_prev;
      ev = en && (e != 2'b00);
      dropped = 1'b0;
      if (rdy && q.size() > 0) void'(q.pop_front());
      if (ev) begin
        if (q.size() < DEPTH) q.push_back({e, m_ts[TS_W-1:0]});
        else dropped = 1'b1;
      end
      if (clr) begin m_ovf = 1'b0; m_drops = 0; end
      if (dropped) begin
        m_ovf = 1'b1;
        if (m_drops < 255) m_drops++;
      end
      m_prev = sp;
      if (en) m_ts = (m_ts + 1) % (1 << TS_W);
    end
    chk("ev_valid", 32'(ev_valid), 32'(q.size() > 0));
    chk("fifo_count", 32'(fifo_count), 32'(q.size()));
    if (q.size() > 0) chk("ev_data", 32'(ev_data), 32'(q[0]));
    else if (rs) chk("ev_data_rst", 32'(ev_data), 32'd0);
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt), exp_drops(m_drops));
  endtask

  task automatic run_to_ts(input int t);
    for (int i = 0; i < 64 && m_ts != t; i++) cycle(2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("reach_ts", 32'(m_ts), 32'(t));
  endtask

  initial begin
    logic [7:0] ev_n1_10;
    ev_n1_10 = 8'({EV_N1, 5'd10});

    cycle(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_count", 32'(fifo_count), 32'd0);

    // Single spike held for 5 cycles starting at ts=10.
    run_to_ts(10);
    cycle(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("single_ev", 32'(ev_data), 32'(ev_n1_10));
    for (int i = 0; i < 4; i++) cycle(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("single_cnt", 32'(fifo_count), 32'd1);
    cycle(2'b00, 1'b1, 1'b1, 1'b0, 1'b0);

    // Coincident spikes and a second neuron joining a held one.
    run_to_ts(20);
    cycle(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("both_ev", 32'(ev_data), 32'({EV_BOTH, 5'd20}));
    cycle(2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    run_to_ts(29);
    cycle(2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("n2_ev", 32'(ev_data), 32'({EV_N2, 5'd30}));
    cycle(2'b00, 1'b1, 1'b1, 1'b0, 1'b0);

    // Overflow: 10 edges into a depth-8 FIFO, then push+pop while full.
    for (int i = 0; i < 10; i++) begin
      cycle(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    chk("ovf_cnt", 32'(fifo_count), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_drops", 32'(drop_cnt), exp_drops(2));
    cycle(2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("pp_cnt", 32'(fifo_count), 32'd8);
    chk("pp_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) cycle(2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("clr_ovf", 32'(overflow), 32'd0);

    // Drop coinciding with clr_ovf: the drop wins.
    for (int i = 0; i < 8; i++) begin
      cycle(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    cycle(2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("clrdrop_ovf", 32'(overflow), 32'd1);
    chk("clrdrop_cnt", 32'(drop_cnt), exp_drops(1));
    for (int i = 0; i < 8; i++) cycle(2'b00, 1'b1, 1'b1, 1'b0, 1'b0);

    // Timestamp wrap, then disabled toggling and re-enable with spikes held high.
    run_to_ts(31);
    cycle(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("wrap_a", 32'(ev_data), 32'({EV_N1, 5'd31}));
    cycle(2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("wrap_b", 32'(ev_data), 32'({EV_N2, 5'd0}));
    for (int i = 0; i < 6; i++) cycle((i % 2) ? 2'b11 : 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("dis_cnt", 32'(fifo_count), 32'd1);
    cycle(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("reen_cnt", 32'(fifo_count), 32'd1);
    cycle(2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("frozen_ts", 32'(ev_data), 32'({EV_N1, 5'd4}));

    // Reset with five events queued and overflow still set.
    for (int i = 0; i < 4; i++) begin
      cycle(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    chk("pre_rst_cnt", 32'(fifo_count), 32'd5);
    cycle(2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_valid", 32'(ev_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    cycle(2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_ts", 32'(ev_data), 32'({EV_N2, 5'd0}));

    // Random traffic with occasional clears and resets.
    for (int i = 0; i < 500; i++) begin
      cycle(2'($urandom_range(0, 3)),
            ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 149) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "simulation did not finish");
  end

endmodule

// File: doc/spike_event_logger.md
# spike_event_logger

Downstream consumer of the two-neuron HH/STDP core's spike outputs. Detects rising edges on each neuron's spike line and stamps each detection with a free-running cycle timestamp. Buffers the resulting events in a small synchronous FIFO and hands them to a readout or serializer stage over a valid/ready handshake. Lets spike timing be recovered off-chip without sampling every cycle.

## Interface
- `TS_W`, 12: timestamp width in bits; timestamp wraps modulo 2^TS_W.
- `DEPTH`, 8: FIFO depth in events; must be a power of two, ≥2.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous reset, active-high.
- `ena` in 1: enable for the timestamp counter and event capture.
- `spike_in` in 2: bit0 = neuron 1 spike, bit1 = neuron 2 spike; level signals, may stay high for several cycles.
- `ev_ready` in 1: downstream accepts the head event.
- `clr_ovf` in 1: clears `overflow` and `drop_cnt`.
- `ev_valid` out 1: FIFO is non-empty.
- `ev_data` out TS_W+2: head event, {mask[1:0], ts[TS_W-1:0]}.
- `fifo_count` out clog2(DEPTH)+1: number of entries stored.
- `overflow` out 1: sticky flag; set when an event is dropped.
- `drop_cnt` out 8: saturating dropped-event count (see Configuration).

## Operation
- **Reset** clears everything: timestamp 0, edge history `prev` 0, FIFO empty, `ev_valid` 0, `ev_data` 0, `fifo_count` 0, `overflow` 0, `drop_cnt` 0.
- **Timestamp** `ts` increments by 1 every cycle while `ena`=1, wraps from 2^TS_W−1 to 0, and holds while `ena`=0.
- **Edge detect:** `edge = spike_in & ~prev`. `prev <= spike_in` every cycle, regardless of `ena`, so re-enabling never produces a false edge.
- **Capture:** if `ena`=1 and `edge`≠0, one event {edge, ts} is generated.
  - The stored ts is the pre-increment value for that cycle.
  - Simultaneous spikes on both neurons give one event with mask 2'b11, never two events.
- **Push:** the event is written if the FIFO is not full, or if it is full and a pop occurs in the same cycle (pop frees the slot first).
- **Drop:** otherwise the event is discarded, `overflow` is set, and `drop_cnt` increments (when compiled in).
- **Pop:** happens when `ev_valid` and `ev_ready` are both 1 on a clock edge. `ev_ready` while empty has no effect.
- **Simultaneous push and pop:** `fifo_count` is unchanged, and the data order is preserved.
- **`clr_ovf`:** clears `overflow` and `drop_cnt`. If a drop occurs in the same cycle, the drop wins: `overflow`=1 and `drop_cnt`=1.
- **Mid-operation reset:** `rst` asserted at any time empties the FIFO and discards pending events. No event is generated on the cycle `rst` is high.

## Timing
- **Capture latency:** `spike_in` rising at edge k → event written at edge k → `ev_valid`=1 and `ev_data` valid after edge k, so it is visible one cycle after sampling.
- `ev_data` comes directly from the head register or memory read; it is stable while `ev_valid`=1 and `ev_ready`=0.
- **Throughput:** 1 event per cycle in, 1 pop per cycle out.
- `fifo_count`, `overflow` and `drop_cnt` are registered and update on the same edge as the push or pop.

## Configuration
- Macro: `SPIKE_LOG_DROP_CNT_EN`.
- **Defined:** `drop_cnt` is an 8-bit counter that saturates at 255, counts each dropped event, and is cleared by `rst` or `clr_ovf`.
- **Undefined:** the counter logic is omitted and `drop_cnt` is tied to 0. `overflow` behaves identically in both builds.

## Structure
- Package `spike_log_pkg` holds:
  - default `TS_W`;
  - the `spike_ev_t` packed struct {mask[1:0], ts[TS_W-1:0]};
  - the mask encodings `EV_N1`=2'b01, `EV_N2`=2'b10, `EV_BOTH`=2'b11.
- Sub-module `spike_fifo`: a generic synchronous FIFO with these signals:
  - push/pop, full/empty, count;
  - parameters WIDTH and DEPTH;
  - pointers one bit wider than the address, with full/empty derived from them.
- The top level contains the timestamp counter, edge detect, drop logic and the optional counter.

## Test plan
- **Single spike:** after reset, `spike_in`=01 for 5 cycles starting with ts=10 → exactly one event {01, 10}; `ev_valid` rises one cycle later; `fifo_count`=1.
- **Coincident spikes:** `spike_in` 00→11 at ts=20 → one event {11, 20}. Also check `spike_in` 01→11 at ts=30 → event {10, 30}.
- **Overflow:** hold `ev_ready`=0 and generate 10 distinct edges with DEPTH=8 →
  - `fifo_count`=8, `overflow`=1;
  - `drop_cnt`=2 with the macro, 0 without;
  - draining returns the first 8 events in order.
- **Full with push+pop:** FIFO full, `ev_ready`=1 and a new edge in the same cycle → event accepted, `fifo_count` stays 8, `overflow` unchanged.
- **Wrap and enable:** TS_W=4, capture at ts=15, then 1 cycle later → stamps 15 and 0. Then deassert `ena` for 6 cycles while toggling `spike_in` → no events and ts frozen; re-enable with `spike_in` held high → no event.
- **Reset mid-stream:** 5 events queued, `rst` for 1 cycle → `ev_valid`=0, `fifo_count`=0, `overflow`=0, and ts restarts at 0.
